// File: rtl/hsi_mse_pkg.sv
// Shared widths and state type for the MSE minimum tracker.
package hsi_mse_pkg;

    localparam int HM_DATA_WIDTH_ACC = 32;
    localparam int HM_LEN_WIDTH      = 8;
    localparam int HM_REF_WIDTH      = 8;

    typedef enum logic [1:0] {
        MT_IDLE,
        MT_RUN,
        MT_DIVIDE,
        MT_DONE
    } mse_tracker_state_t;

endpackage

// File: rtl/mse_min_tracker_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// The first iteration is folded into the load cycle, so done rises exactly
// DATA_WIDTH cycles after start. A start while busy restarts the division.
module seq_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] rem, quo, src_rem, src_quo, step_rem, step_quo;
    logic [DATA_WIDTH:0]   trial;
    logic                  ge;
    logic [CW-1:0]         remaining;
    logic                  running;

    // One restoring step, taken either from the fresh operands or the running state.
    always_comb begin
        src_rem  = start ? '0 : rem;
        src_quo  = start ? dividend : quo;
        trial    = {src_rem, src_quo[DATA_WIDTH-1]};
        ge       = (trial >= {1'b0, divisor});
        step_rem = ge ? (trial[DATA_WIDTH-1:0] - divisor) : trial[DATA_WIDTH-1:0];
        step_quo = {src_quo[DATA_WIDTH-2:0], ge};
    end

    // Iteration register with a down-counter of remaining steps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem       <= '0;
            quo       <= '0;
            remaining <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem       <= step_rem;
                quo       <= step_quo;
                remaining <= CW'(DATA_WIDTH - 1);
                running   <= 1'b1;
            end else if (running) begin
                rem       <= step_rem;
                quo       <= step_quo;
                remaining <= remaining - CW'(1);
                if (remaining == CW'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/mse_min_tracker.sv
// Tracks the minimum per-vector SSE over a reference library and reports
// its index, the SSE and the SSE divided by the vector length.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  MT_IDLE   | waiting for a start with non-zero config
//  MT_RUN    | consuming accumulator beats, updating the running minimum
//  MT_DIVIDE | divider working on min_sse / vector_length
//  MT_DONE   | one-cycle result_valid, then back to idle
import hsi_mse_pkg::*;

module mse_min_tracker #(
    parameter int DATA_WIDTH_ACC = HM_DATA_WIDTH_ACC,
    parameter int LEN_WIDTH      = HM_LEN_WIDTH,
    parameter int REF_WIDTH      = HM_REF_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [LEN_WIDTH-1:0]      vector_length,
    input  logic [REF_WIDTH-1:0]      num_refs,
    input  logic                      acc_valid,
    input  logic [DATA_WIDTH_ACC-1:0] acc_value,
    output logic                      busy,
    output logic                      result_valid,
    output logic [REF_WIDTH-1:0]      min_index,
    output logic [DATA_WIDTH_ACC-1:0] min_sse,
    output logic [DATA_WIDTH_ACC-1:0] min_mse,
    output logic                      overrun
);

    mse_tracker_state_t state, next_state;

    logic [LEN_WIDTH-1:0]      len_q, beat_cnt;
    logic [REF_WIDTH-1:0]      refs_q, ref_cnt;
    logic                      cfg_nonzero, start_ok, beat_run, closing, last_ref, take_new;
    logic                      div_start, div_done;
    logic [DATA_WIDTH_ACC-1:0] best_sse, div_divisor, div_quotient;

    // A start from idle with zero config is ignored; elsewhere it always aborts.
    assign cfg_nonzero = (vector_length != '0) && (num_refs != '0);
    assign start_ok    = start && ((state != MT_IDLE) || cfg_nonzero);

    // start has priority over a coincident beat, which is dropped.
    assign beat_run    = (state == MT_RUN) && acc_valid && !start;
    assign closing     = (beat_cnt == (len_q - LEN_WIDTH'(1)));
    assign last_ref    = (ref_cnt == (refs_q - REF_WIDTH'(1)));
    assign take_new    = (ref_cnt == '0) || (acc_value < min_sse);
    assign best_sse    = take_new ? acc_value : min_sse;
    assign div_start   = beat_run && closing && last_ref;
    assign div_divisor = DATA_WIDTH_ACC'(len_q);

    assign busy         = (state == MT_RUN) || (state == MT_DIVIDE);
    assign result_valid = (state == MT_DONE);

    seq_divider #(
        .DATA_WIDTH(DATA_WIDTH_ACC)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (best_sse),
        .divisor  (div_divisor),
        .done     (div_done),
        .quotient (div_quotient)
    );

    // Next-state decode.
    always_comb begin
        next_state = state;
        if (start_ok) begin
            next_state = cfg_nonzero ? MT_RUN : MT_IDLE;
        end else begin
            case (state)
                MT_IDLE:   next_state = MT_IDLE;
                MT_RUN:    if (div_start) next_state = MT_DIVIDE;
                MT_DIVIDE: if (div_done) next_state = MT_DONE;
                MT_DONE:   next_state = MT_IDLE;
                default:   next_state = MT_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= MT_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Config latch, beat/vector counters, running minimum and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q     <= '0;
            refs_q    <= '0;
            beat_cnt  <= '0;
            ref_cnt   <= '0;
            min_index <= '0;
            min_sse   <= '0;
            min_mse   <= '0;
            overrun   <= 1'b0;
        end else if (start_ok) begin
            len_q     <= vector_length;
            refs_q    <= num_refs;
            beat_cnt  <= '0;
            ref_cnt   <= '0;
            min_index <= '0;
            min_sse   <= '0;
            min_mse   <= '0;
            overrun   <= 1'b0;
        end else begin
            if (acc_valid && ((state == MT_DIVIDE) || (state == MT_DONE))) begin
                overrun <= 1'b1;
            end
            if (beat_run) begin
                if (closing) begin
                    beat_cnt <= '0;
                    ref_cnt  <= ref_cnt + REF_WIDTH'(1);
                    if (take_new) begin
                        min_sse   <= acc_value;
                        min_index <= ref_cnt;
                    end
                end else begin
                    beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                end
            end
            if ((state == MT_DIVIDE) && div_done) begin
                min_mse <= div_quotient;
            end
        end
    end

endmodule
